// File: rtl/ahci_axi_wr_slave_pkg.sv
// ahci_axi_pkg: burst/response encodings and FSM states shared by the AHCI AXI slaves
package ahci_axi_pkg;
    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, RESP = 2'd2} state_e;
endpackage

// File: rtl/ahci_axi_wr_slave_if.sv
// ahci_axi_wr_slave_if: AXI3 AW/W/B channel bundle
interface ahci_axi_wr_slave_if;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [11:0] awid;
    logic [3:0]  awlen;
    logic [1:0]  awsize;
    logic [1:0]  awburst;
    logic [31:0] wdata;
    logic        wvalid;
    logic        wready;
    logic [11:0] wid;
    logic        wlast;
    logic [3:0]  wstb;
    logic        bvalid;
    logic        bready;
    logic [11:0] bid;
    logic [1:0]  bresp;
    modport master (
        output awaddr, awvalid, awid, awlen, awsize, awburst, wdata, wvalid, wid, wlast, wstb, bready,
        input  awready, wready, bvalid, bid, bresp
    );
    modport slave (
        input  awaddr, awvalid, awid, awlen, awsize, awburst, wdata, wvalid, wid, wlast, wstb, bready,
        output awready, wready, bvalid, bid, bresp
    );
endinterface

// File: rtl/ahci_burst_addr_gen.sv
// ahci_burst_addr_gen: next dword address of an AXI burst, flags WRAP lengths that are not 2/4/8/16 beats
module ahci_burst_addr_gen
    import ahci_axi_pkg::*;
#(
    parameter int ADDRESS_BITS = 10
) (
    input  logic [ADDRESS_BITS-1:0] addr_i,
    input  logic [3:0]              len_i,
    input  logic [1:0]              burst_i,
    output logic [ADDRESS_BITS-1:0] next_o,
    output logic                    bad_wrap_o
);
    logic [ADDRESS_BITS-1:0] inc, mask;
    assign inc        = addr_i + ADDRESS_BITS'(1);
    assign mask       = ADDRESS_BITS'(len_i);
    assign bad_wrap_o = burst_i == BURST_WRAP && !(len_i inside {4'd1, 4'd3, 4'd7, 4'd15});
    // a valid wrap only advances the bits inside the aligned window; bad wraps fall back to INCR
    assign next_o = burst_i == BURST_FIXED                 ? addr_i :
                    burst_i == BURST_WRAP && !bad_wrap_o   ? (addr_i & ~mask) | (inc & mask) :
                                                             inc;
endmodule

// File: rtl/ahci_axi_wr_slave.sv
// ahci_axi_wr_slave: AXI3 write slave producing a dword register-write stream, one burst at a time.
// Define AHCI_WID_CHECK_EN to drop (and flag) beats whose wid differs from the burst's awid.
module ahci_axi_wr_slave
    import ahci_axi_pkg::*;
#(
    parameter int ADDRESS_BITS = 10
) (
    input  logic                    aclk,
    input  logic                    arst,
    ahci_axi_wr_slave_if.slave      axi,
    input  logic                    dev_ready,
    output logic                    start_burst,
    output logic                    pre_wen,
    output logic [ADDRESS_BITS-1:0] reg_waddr,
    output logic                    reg_wen,
    output logic [3:0]              reg_wstb,
    output logic [31:0]             reg_wdata
);
    state_e                  state_q, state_d;
    logic [ADDRESS_BITS-1:0] addr_q, addr_d, addr_nxt, waddr_q, waddr_d;
    logic [3:0]              len_q, len_d, cnt_q, cnt_d, wstb_q, wstb_d;
    logic [1:0]              burst_q, burst_d, bresp_q, bresp_d;
    logic [11:0]             id_q, id_d, bid_q, bid_d;
    logic [31:0]             wdata_q, wdata_d;
    logic                    err_q, err_d, wen_q, wen_d, bad_wrap, beat_end, id_ok, unused_ok;

    ahci_burst_addr_gen #(.ADDRESS_BITS(ADDRESS_BITS)) u_addr_gen (
        .addr_i(addr_q), .len_i(len_q), .burst_i(burst_q), .next_o(addr_nxt), .bad_wrap_o(bad_wrap)
    );

`ifdef AHCI_WID_CHECK_EN
    assign id_ok     = axi.wid == id_q;
    assign unused_ok = ^{axi.awsize, axi.awaddr[31:ADDRESS_BITS+2], axi.awaddr[1:0]};
`else
    assign id_ok     = 1'b1;
    assign unused_ok = ^{axi.awsize, axi.awaddr[31:ADDRESS_BITS+2], axi.awaddr[1:0], axi.wid};
`endif

    assign axi.awready = state_q == IDLE && !arst;
    assign axi.wready  = state_q == DATA && dev_ready;
    assign axi.bvalid  = state_q == RESP;
    assign axi.bid     = bid_q;
    assign axi.bresp   = bresp_q;
    assign start_burst = axi.awvalid && axi.awready;
    assign pre_wen     = axi.wvalid && axi.wready;
    assign beat_end    = cnt_q == len_q;
    assign reg_waddr   = waddr_q;
    assign reg_wen     = wen_q;
    assign reg_wstb    = wstb_q;
    assign reg_wdata   = wdata_q;

    always_ff @(posedge aclk) begin
        if (arst) begin
            state_q <= IDLE;
            {addr_q, waddr_q, len_q, cnt_q, wstb_q, burst_q, bresp_q} <= '0;
            {id_q, bid_q, wdata_q, err_q, wen_q} <= '0;
        end else begin
            state_q <= state_d;
            {addr_q, waddr_q, len_q, cnt_q, wstb_q, burst_q, bresp_q} <=
                {addr_d, waddr_d, len_d, cnt_d, wstb_d, burst_d, bresp_d};
            {id_q, bid_q, wdata_q, err_q, wen_q} <= {id_d, bid_d, wdata_d, err_d, wen_d};
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        burst_d = burst_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        bid_d   = bid_q;
        bresp_d = bresp_q;
        waddr_d = waddr_q;
        wstb_d  = wstb_q;
        wdata_d = wdata_q;
        wen_d   = 1'b0;
        if (start_burst) begin
            addr_d  = axi.awaddr[ADDRESS_BITS+1:2];
            len_d   = axi.awlen;
            burst_d = axi.awburst;
            id_d    = axi.awid;
            cnt_d   = 4'd0;
            err_d   = 1'b0;
            state_d = DATA;
        end
        if (pre_wen) begin
            wen_d   = id_ok;
            waddr_d = addr_q;
            wstb_d  = axi.wstb;
            wdata_d = axi.wdata;
            addr_d  = addr_nxt;
            cnt_d   = cnt_q + 4'd1;
            // a missing or premature wlast still ends the burst, but as SLVERR
            err_d   = err_q || bad_wrap || (beat_end != axi.wlast) || !id_ok;
            state_d = beat_end || axi.wlast ? RESP : DATA;
            bid_d   = beat_end || axi.wlast ? id_q : bid_q;
            bresp_d = beat_end || axi.wlast ? (err_d ? RESP_SLVERR : RESP_OKAY) : bresp_q;
        end
        if (axi.bvalid && axi.bready) state_d = IDLE;
    end
endmodule

// File: tb/tb_ahci_axi_wr_slave.sv
// tb_ahci_axi_wr_slave: randomized and directed bursts checked against a queue-based burst model
module tb_ahci_axi_wr_slave;
    import ahci_axi_pkg::*;

    typedef struct packed {logic [9:0] a; logic [3:0] s; logic [31:0] d;} wr_t;
    typedef struct packed {logic [11:0] id; logic [1:0] r; logic lw;} rsp_t;

`ifdef AHCI_WID_CHECK_EN
    localparam bit WID_CHECK = 1'b1;
`else
    localparam bit WID_CHECK = 1'b0;
`endif

    logic        aclk = 1'b0, arst = 1'b1;
    logic        dev_ready, start_burst, pre_wen, reg_wen;
    logic [9:0]  reg_waddr;
    logic [3:0]  reg_wstb;
    logic [31:0] reg_wdata;

    ahci_axi_wr_slave_if axi();

    ahci_axi_wr_slave #(.ADDRESS_BITS(10)) dut (
        .aclk(aclk), .arst(arst), .axi(axi), .dev_ready(dev_ready), .start_burst(start_burst),
        .pre_wen(pre_wen), .reg_waddr(reg_waddr), .reg_wen(reg_wen), .reg_wstb(reg_wstb),
        .reg_wdata(reg_wdata)
    );

    always #5 aclk = ~aclk;
    assign dev_ready = !reg_wen;

    int          total = 0, passed = 0, cyc = 0;
    wr_t         exp_wr[$];
    rsp_t        exp_rsp[$];
    logic [9:0]  obs_a[$];
    int          obs_c[$];
    wr_t         cw;
    logic        bv_prev = 1'b0;
    logic [11:0] last_bid;
    logic [1:0]  last_bresp;
    logic [3:0]  last_wstb;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // where beat i of a burst must land, straight from the burst-type rules
    function automatic logic [9:0] model_addr(input logic [9:0] a0, input int len, input logic [1:0] bt, input int i);
        int n, a;
        n = len + 1;
        a = int'(a0);
        if (bt == BURST_FIXED) return a0;
        if (bt == BURST_WRAP && (n == 2 || n == 4 || n == 8 || n == 16)) return 10'((a / n) * n + (a % n + i) % n);
        return 10'((a + i) % 1024);
    endfunction

    always @(posedge aclk) cyc++;

    always @(negedge aclk) begin
        if (reg_wen) begin
            if (exp_wr.size() == 0) chk("wen_unexpected", reg_wen, 0);
            else begin
                cw = exp_wr.pop_front();
                chk("waddr", reg_waddr, cw.a);
                chk("wstb", reg_wstb, cw.s);
                chk("wdata", reg_wdata, cw.d);
            end
            obs_a.push_back(reg_waddr);
            obs_c.push_back(cyc);
            last_wstb = reg_wstb;
        end
        if (axi.bvalid && !bv_prev) begin
            if (exp_rsp.size() == 0) chk("bvalid_unexpected", axi.bvalid, 0);
            else begin
                chk("bid", axi.bid, exp_rsp[0].id);
                chk("bresp", axi.bresp, exp_rsp[0].r);
                chk("bvalid_with_last_wen", reg_wen, exp_rsp[0].lw);
                chk("writes_drained", exp_wr.size(), 0);
            end
            last_bid   = axi.bid;
            last_bresp = axi.bresp;
        end
        bv_prev <= axi.bvalid;
    end

    task automatic send_aw(input logic [31:0] addr, input int len, input logic [1:0] bt, input logic [11:0] id);
        int k;
        @(negedge aclk);
        axi.awvalid = 1'b1;
        axi.awaddr  = addr;
        axi.awlen   = 4'(len);
        axi.awburst = bt;
        axi.awid    = id;
        axi.awsize  = 2'($urandom);
        #1;
        k = 0;
        while (!axi.awready && k < 100) begin @(negedge aclk); #1; k++; end
        if (k >= 100) chk("aw_timeout", axi.awready, 1);
        chk("start_burst", start_burst, 1);
        @(posedge aclk);
        @(negedge aclk);
        axi.awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s, input logic [11:0] wid, input bit last);
        int k;
        axi.wvalid = 1'b1;
        axi.wdata  = d;
        axi.wstb   = s;
        axi.wid    = wid;
        axi.wlast  = last;
        #1;
        k = 0;
        while (!axi.wready && k < 100) begin @(negedge aclk); #1; k++; end
        if (k >= 100) chk("w_timeout", axi.wready, 1);
        @(posedge aclk);
        @(negedge aclk);
        axi.wvalid = 1'b0;
        axi.wlast  = 1'b0;
    endtask

    task automatic recv_b(input bit early);
        int k;
        axi.bready = early;
        #1;
        k = 0;
        while (!axi.bvalid && k < 100) begin @(negedge aclk); #1; k++; end
        if (k >= 100) begin
            chk("b_timeout", axi.bvalid, 1);
            if (exp_rsp.size() != 0) void'(exp_rsp.pop_front());
            exp_wr.delete();
            axi.bready = 1'b0;
            return;
        end
        if (!early) begin
            repeat ($urandom_range(0, 2)) begin @(negedge aclk); #1; chk("b_hold", axi.bvalid, 1); end
            axi.bready = 1'b1;
        end
        @(posedge aclk);
        if (exp_rsp.size() != 0) void'(exp_rsp.pop_front());
        @(negedge aclk);
        axi.bready = 1'b0;
    endtask

    task automatic run_burst(input logic [31:0] addr, input int len, input logic [1:0] bt, input logic [11:0] id,
                             input int wlast_at, input logic [15:0] bad, input bit early, input int gmax,
                             input bit rstb, input logic [3:0] stb);
        int          n;
        bit          err, lw;
        logic [31:0] d[16];
        logic [3:0]  s[16];
        n   = (wlast_at >= 1 && wlast_at <= len + 1) ? wlast_at : len + 1;
        err = (wlast_at != len + 1) || (bt == BURST_WRAP && !(len == 1 || len == 3 || len == 7 || len == 15));
        lw  = 1'b1;
        for (int i = 0; i < n; i++) begin
            d[i] = $urandom;
            s[i] = rstb ? 4'($urandom) : stb;
            if (WID_CHECK && bad[i]) begin
                err = 1'b1;
                if (i == n - 1) lw = 1'b0;
            end else exp_wr.push_back('{model_addr(addr[11:2], len, bt, i), s[i], d[i]});
        end
        exp_rsp.push_back('{id, err ? RESP_SLVERR : RESP_OKAY, lw});
        send_aw(addr, len, bt, id);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, gmax)) @(negedge aclk);
            send_w(d[i], s[i], bad[i] ? id ^ 12'h2 : id, (i + 1) == wlast_at);
        end
        recv_b(early);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
        $fatal(1);
    end

    initial begin
        {axi.awaddr, axi.awvalid, axi.awid, axi.awlen, axi.awsize, axi.awburst} = '0;
        {axi.wdata, axi.wvalid, axi.wid, axi.wlast, axi.wstb, axi.bready} = '0;
        chk("model_wrap", model_addr(10'h0E, 3, BURST_WRAP, 2), 10'h0C);
        chk("model_badwrap", model_addr(10'h0E, 2, BURST_WRAP, 2), 10'h10);
        chk("model_incr_wrap", model_addr(10'h3FF, 1, BURST_INCR, 1), 10'h000);
        chk("model_fixed", model_addr(10'h040, 2, BURST_FIXED, 2), 10'h040);
        repeat (3) @(negedge aclk);
        axi.awvalid = 1'b1;
        axi.wvalid  = 1'b1;
        #1;
        chk("rst_awready", axi.awready, 0);
        chk("rst_start_burst", start_burst, 0);
        chk("rst_wready", axi.wready, 0);
        chk("rst_bvalid", axi.bvalid, 0);
        chk("rst_reg_wen", reg_wen, 0);
        chk("rst_reg_waddr", reg_waddr, 0);
        chk("rst_reg_wstb", reg_wstb, 0);
        chk("rst_reg_wdata", reg_wdata, 0);
        chk("rst_bid", axi.bid, 0);
        chk("rst_bresp", axi.bresp, 0);
        axi.awvalid = 1'b0;
        arst = 1'b0;
        @(negedge aclk); #1;
        chk("idle_awready", axi.awready, 1);
        chk("idle_wready", axi.wready, 0);
        chk("idle_pre_wen", pre_wen, 0);
        axi.wvalid = 1'b0;

        obs_a.delete(); obs_c.delete();
        run_burst(32'h40, 3, BURST_INCR, 12'hABC, 4, 0, 1'b0, 0, 1'b1, 4'h0);
        chk("incr_n", obs_a.size(), 4);
        chk("incr_a0", obs_a[0], 10'h10);
        chk("incr_a3", obs_a[3], 10'h13);
        chk("incr_alt_cycles", obs_c[1] - obs_c[0], 2);
        chk("incr_bid", last_bid, 12'hABC);
        chk("incr_bresp", last_bresp, 2'b00);

        obs_a.delete();
        run_burst(32'h38, 3, BURST_WRAP, 12'h001, 4, 0, 1'b1, 1, 1'b1, 4'h0);
        chk("wrap_a2", obs_a[2], 10'h0C);
        chk("wrap_a3", obs_a[3], 10'h0D);
        chk("wrap_bresp", last_bresp, 2'b00);

        obs_a.delete();
        run_burst(32'h38, 2, BURST_WRAP, 12'h002, 3, 0, 1'b0, 0, 1'b1, 4'h0);
        chk("badwrap_a2", obs_a[2], 10'h10);
        chk("badwrap_bresp", last_bresp, 2'b10);

        obs_a.delete();
        run_burst(32'h100, 2, BURST_FIXED, 12'h003, 3, 0, 1'b1, 0, 1'b0, 4'b0011);
        chk("fixed_a2", obs_a[2], 10'h40);
        chk("fixed_wstb", last_wstb, 4'b0011);

        obs_a.delete();
        run_burst(32'hFFC, 1, BURST_INCR, 12'h004, 2, 0, 1'b0, 0, 1'b1, 4'h0);
        chk("top_a0", obs_a[0], 10'h3FF);
        chk("top_a1", obs_a[1], 10'h000);

        obs_a.delete();
        run_burst(32'h200, 3, BURST_INCR, 12'h006, 2, 0, 1'b1, 0, 1'b1, 4'h0);
        chk("early_n", obs_a.size(), 2);
        chk("early_bresp", last_bresp, 2'b10);

        obs_a.delete();
        run_burst(32'h240, 1, BURST_INCR, 12'h007, 0, 0, 1'b0, 0, 1'b1, 4'h0);
        chk("nolast_n", obs_a.size(), 2);
        chk("nolast_bresp", last_bresp, 2'b10);

        // reset in the second DATA cycle: the beat already handshaked is the only write
        send_aw(32'h200, 3, BURST_INCR, 12'h011);
        exp_wr.push_back('{10'h080, 4'hF, 32'hDEAD_BEEF});
        axi.wvalid = 1'b1; axi.wdata = 32'hDEAD_BEEF; axi.wstb = 4'hF; axi.wid = 12'h011;
        #1;
        chk("rst_test_wready", axi.wready, 1);
        @(posedge aclk);
        @(negedge aclk);
        axi.wvalid = 1'b0;
        arst = 1'b1;
        @(negedge aclk); #1;
        chk("midrst_reg_wen", reg_wen, 0);
        chk("midrst_bvalid", axi.bvalid, 0);
        chk("midrst_awready", axi.awready, 0);
        arst = 1'b0;
        @(negedge aclk); #1;
        chk("postrst_awready", axi.awready, 1);
        chk("postrst_drained", exp_wr.size(), 0);
        run_burst(32'h300, 1, BURST_INCR, 12'h012, 2, 0, 1'b1, 0, 1'b1, 4'h0);
        chk("postrst_bresp", last_bresp, 2'b00);

        obs_a.delete();
        run_burst(32'h300, 2, BURST_INCR, 12'h005, 3, 16'b010, 1'b1, 0, 1'b1, 4'h0);
        chk("wid_n", obs_a.size(), WID_CHECK ? 2 : 3);
        chk("wid_bresp", last_bresp, WID_CHECK ? 2'b10 : 2'b00);

        for (int b = 0; b < 60; b++) begin
            int len, wl;
            len = $urandom_range(0, 15);
            wl  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 16) : len + 1;
            run_burst($urandom, len, 2'($urandom), 12'($urandom), wl,
                      ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0,
                      1'($urandom), 2, 1'b1, 4'h0);
        end

        repeat (4) @(negedge aclk);
        chk("end_rsp_drained", exp_rsp.size(), 0);
        chk("end_wr_drained", exp_wr.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/ahci_axi_wr_slave.md
Name: ahci_axi_wr_slave

Overview:
AXI3 write-channel slave that turns AW/W bursts into a register-write stream: one dword address, byte strobes, data and write-enable per beat. It sits directly upstream of the AHCI register file and feeds that block's two-cycle read-modify-write port. It handles burst address generation, downstream back-pressure via dev_ready, WLAST checking and the B-channel response. One burst is outstanding at a time.

Parameters:
ADDRESS_BITS, 10, dword address width of the register space; the byte address bits used are awaddr[ADDRESS_BITS+1:2].

Ports:
aclk  in  1  clock
arst  in  1  reset, synchronous, active-high
awaddr  in  32  write byte address
awvalid  in  1  AW valid
awready  out  1  AW ready
awid  in  12  AW id
awlen  in  4  beats minus 1
awsize  in  2  ignored; every beat is one dword, wstb selects bytes
awburst  in  2  0 FIXED, 1 INCR, 2 WRAP, 3 reserved (treated as INCR)
wdata  in  32  write data
wvalid  in  1  W valid
wready  out  1  W ready
wid  in  12  W id
wlast  in  1  last beat
wstb  in  4  byte strobes
bvalid  out  1  B valid
bready  in  1  B ready
bid  out  12  response id
bresp  out  2  2'b00 OKAY, 2'b10 SLVERR
dev_ready  in  1  downstream can take a beat this cycle
start_burst  out  1  one-cycle pulse on AW handshake
pre_wen  out  1  combinational W handshake (wvalid && wready)
reg_waddr  out  ADDRESS_BITS  dword address of the beat
reg_wen  out  1  registered beat strobe
reg_wstb  out  4  registered strobes
reg_wdata  out  32  registered data

Behaviour:
- Reset values: state IDLE; awready, wready, bvalid, reg_wen, start_burst = 0; reg_waddr, reg_wstb, reg_wdata, bid, bresp = 0.
- FSM states IDLE, DATA, RESP.
  - IDLE: awready=1 (0 while arst). On awvalid&&awready, latch the dword address, awlen, awburst and awid; clear the beat counter and error flag; pulse start_burst; move to DATA next cycle.
  - DATA: wready = dev_ready (combinational). The downstream ties dev_ready = !reg_wen, which gives one beat per two cycles.
  - RESP: bvalid=1 with bid = latched awid and bresp = error ? 2'b10 : 2'b00. Hold until bready, then IDLE. awready=0 throughout DATA and RESP.
- Beat timing: a W handshake at cycle M drives reg_wen=1 at M+1 with the handshaked wstb and wdata and the current burst address. reg_wen is high for exactly one cycle per beat.
- Address update after each beat:
  - FIXED: unchanged.
  - INCR: +1, modulo 2^ADDRESS_BITS (the top address wraps to 0).
  - WRAP: +1 within an aligned window of awlen+1 dwords. Only the low log2(awlen+1) bits increment. A WRAP with awlen not in {1,3,7,15} is handled as INCR and sets error.
- Termination is decided at the beat handshake; RESP is entered at M+1, and bvalid rises in the same cycle as the last reg_wen.
  - Beat count == awlen with wlast=1: normal end.
  - Beat count == awlen with wlast=0: end anyway, set error.
  - wlast=1 with beat count < awlen: early end, set error; the beat is still written.
- wvalid outside DATA is not accepted (wready=0).
- bready may be held high in advance; completion is then a single cycle in RESP.
- Reset mid-burst: immediate return to IDLE, no bvalid, any pending reg_wen cleared. The master is responsible for dropping the transaction.

Optional Feature:
AHCI_WID_CHECK_EN
- Defined: a beat whose wid differs from the latched awid is still handshaked but not written (reg_wen stays 0 for it); it sets error and counts toward termination.
- Undefined: wid is ignored.

Decomposition:
- Package ahci_axi_pkg: the BURST_FIXED/INCR/WRAP constants, RESP_OKAY/RESP_SLVERR constants, and the state encoding IDLE=0, DATA=1, RESP=2.
- One natural sub-module, ahci_burst_addr_gen (combinational next address from address, awlen and awburst, plus the invalid-wrap flag), reusable by a read-side slave.

Test Plan:
- INCR, awaddr=0x40, awlen=3, dev_ready=!reg_wen, wlast on beat 4 -> reg_wen pulses on alternate cycles at reg_waddr 0x10,0x11,0x12,0x13; bvalid with bresp=00 and bid=awid.
- WRAP, awaddr=0x38 (dword 0x0E), awlen=3 -> reg_waddr 0x0E,0x0F,0x0C,0x0D; OKAY. WRAP with awlen=2 -> INCR order and SLVERR.
- FIXED, awlen=2, wstb=4'b0011 -> three writes to the same address, reg_wstb=0011; INCR starting at dword 0x3FF with awlen=1 -> addresses 0x3FF then 0x000.
- awlen=3 with wlast on beat 2 -> two writes, bresp=10. awlen=1 with no wlast -> two writes, bresp=10.
- arst asserted on cycle 2 of DATA -> no further reg_wen, bvalid=0, awready=1 the cycle after arst drops; a following burst completes OKAY.
- With AHCI_WID_CHECK_EN, awid=5, beats with wid=5,7,5 -> writes for beats 1 and 3 only, bresp=10. Without the macro, all three are written, OKAY.
